// File: rtl/i2c_slave_responder_if.sv
// Pin and fabric signals of the I2C target responder.
// The slave modport is the responder; the master modport is the side that
// drives the pins and serves the fabric data.
interface i2c_slave_responder_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_drive_low;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       addressed;
  logic       bus_busy;

  modport slave (
    input  scl_in, sda_in, rx_ready, tx_data,
    output sda_drive_low, rx_data, rx_valid, tx_load, addressed, bus_busy
  );

  modport master (
    output scl_in, sda_in, rx_ready, tx_data,
    input  sda_drive_low, rx_data, rx_valid, tx_load, addressed, bus_busy
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target responder: oversamples SCL/SDA, detects START/STOP, matches a
// 7-bit address, receives write bytes and transmits fabric-supplied read bytes.
// SDA is only ever pulled low (open drain); SCL is never driven.
module i2c_slave_responder #(
  parameter logic [6:0]  ADDRESS     = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   reset_n,
  i2c_slave_responder_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_RX_BYTE   = 3'd3;
  localparam logic [2:0] S_RX_ACK    = 3'd4;
  localparam logic [2:0] S_TX_BYTE   = 3'd5;
  localparam logic [2:0] S_TX_ACKCHK = 3'd6;
  localparam logic [2:0] S_IGNORE    = 3'd7;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_hist;
  logic                   r_sda_hist;

  logic [2:0] r_state;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic [7:0] r_tx_shift;
  logic       r_rw;
  logic       r_phase;
  logic       r_rx_ack;
  logic       r_sda_drive;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_load;
  logic       r_addressed;
  logic       r_busy;

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;

  // Synchronize the raw pins and keep one history sample for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_scl_sync <= '0;
      r_sda_sync <= '0;
      r_scl_hist <= 1'b0;
      r_sda_hist <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
      r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_hist;
  assign w_scl_fall = ~w_scl & r_scl_hist;
  assign w_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
  assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};

  // Protocol FSM; START/STOP take priority over every state and over scl_fall
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_tx_shift  <= '0;
      r_rw        <= 1'b0;
      r_phase     <= 1'b0;
      r_rx_ack    <= 1'b0;
      r_sda_drive <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_load   <= 1'b0;
      r_addressed <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
      if (r_rx_valid) begin
        r_rx_ack <= bus.rx_ready;
      end
      if (w_stop) begin
        r_state     <= S_IDLE;
        r_sda_drive <= 1'b0;
        r_addressed <= 1'b0;
        r_busy      <= 1'b0;
        r_phase     <= 1'b0;
      end else if (w_start) begin
        r_state     <= S_ADDR;
        r_bitcnt    <= '0;
        r_sda_drive <= 1'b0;
        r_addressed <= 1'b0;
        r_busy      <= 1'b1;
        r_phase     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sda_drive <= 1'b0;
          end
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                if (w_byte[7:1] == ADDRESS) begin
                  r_rw    <= w_byte[0];
                  r_phase <= 1'b0;
                  r_state <= S_ADDR_ACK;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_drive <= 1'b1;
                r_addressed <= 1'b1;
                r_phase     <= 1'b1;
              end else begin
                r_sda_drive <= 1'b0;
                r_phase     <= 1'b0;
                r_bitcnt    <= '0;
                if (r_rw) begin
                  r_tx_load <= 1'b1;
                  r_state   <= S_TX_BYTE;
                end else begin
                  r_state   <= S_RX_BYTE;
                end
              end
            end
          end
          S_RX_BYTE: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_rx_data  <= w_byte;
                r_rx_valid <= 1'b1;
                r_phase    <= 1'b0;
                r_state    <= S_RX_ACK;
              end
            end
          end
          S_RX_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_drive <= r_rx_ack;
                r_phase     <= 1'b1;
              end else begin
                r_sda_drive <= 1'b0;
                r_phase     <= 1'b0;
                r_bitcnt    <= '0;
                r_state     <= S_RX_BYTE;
              end
            end
          end
          S_TX_BYTE: begin
            // tx_data is taken during the tx_load cycle, so the MSB appears
            // one clk after the releasing scl_fall, still well inside SCL low
            if (r_tx_load) begin
              r_tx_shift  <= bus.tx_data;
              r_sda_drive <= ~bus.tx_data[7];
            end else if (w_scl_fall) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_sda_drive <= 1'b0;
                r_phase     <= 1'b0;
                r_state     <= S_TX_ACKCHK;
              end else begin
                r_tx_shift  <= {r_tx_shift[6:0], 1'b0};
                r_sda_drive <= ~r_tx_shift[6];
              end
            end
          end
          S_TX_ACKCHK: begin
            r_sda_drive <= 1'b0;
            if (w_scl_rise) begin
              if (w_sda) begin
                r_state <= S_IGNORE;
              end else begin
                r_phase <= 1'b1;
              end
            end else if (w_scl_fall && r_phase) begin
              r_tx_load <= 1'b1;
              r_bitcnt  <= '0;
              r_phase   <= 1'b0;
              r_state   <= S_TX_BYTE;
            end
          end
          S_IGNORE: begin
            r_sda_drive <= 1'b0;
          end
          default: begin
            r_state     <= S_IDLE;
            r_sda_drive <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_drive_low = r_sda_drive;
  assign bus.rx_data       = r_rx_data;
  assign bus.rx_valid      = r_rx_valid;
  assign bus.tx_load       = r_tx_load;
  assign bus.addressed     = r_addressed;
  assign bus.bus_busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master with wired-AND SDA,
// a table of write transactions plus directed read/restart/reset sequences.
module tb_i2c_slave_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  i2c_slave_responder_if bus ();

  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       m_ready = 1'b1;
  logic [7:0] m_txd = 8'h00;

  assign bus.scl_in   = m_scl;
  assign bus.sda_in   = m_sda & ~bus.sda_drive_low;
  assign bus.rx_ready = m_ready;
  assign bus.tx_data  = m_txd;

  i2c_slave_responder #(.ADDRESS(7'h50), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned mon_rx  = 0;
  int unsigned mon_tx  = 0;
  int unsigned mon_drv = 0;
  logic [7:0]  mon_last = 8'h00;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      mon_rx   = mon_rx + 1;
      mon_last = bus.rx_data;
    end
    if (bus.tx_load === 1'b1) mon_tx = mon_tx + 1;
    if (bus.sda_drive_low === 1'b1) mon_drv = mon_drv + 1;
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned Q = 25;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic wq(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    m_sda = b;
    wq(Q);
    m_scl = 1'b1;
    wq(Q);
    s = bus.sda_in;
    wq(Q);
    m_scl = 1'b0;
    wq(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b0;
    wq(Q);
    m_scl = 1'b0;
    wq(Q);
  endtask

  task automatic i2c_restart();
    m_sda = 1'b1;
    wq(Q);
    m_scl = 1'b1;
    wq(Q);
    m_sda = 1'b0;
    wq(Q);
    m_scl = 1'b0;
    wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wq(Q);
    m_scl = 1'b1;
    wq(Q);
    m_sda = 1'b1;
    wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_bits(output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, s);
      d = {d[6:0], s};
    end
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int unsigned nbytes;
    logic [1:0]  ready;
    logic        exp_aack;
    logic [1:0]  exp_dack;
    int unsigned exp_rx;
    logic [7:0]  exp_last;
    int unsigned q;
  } wvec_t;

  wvec_t vecs[5];

  initial begin
    logic       a;
    logic [7:0] d;
    logic [7:0] db;
    int unsigned rx0, tx0, drv0;

    vecs[0] = '{8'hA0, 8'h3C, 8'h00, 1, 2'b11, 1'b1, 2'b01, 1, 8'h3C, 125};
    vecs[1] = '{8'hA2, 8'h55, 8'h00, 1, 2'b11, 1'b0, 2'b00, 0, 8'h00, 25};
    vecs[2] = '{8'hA0, 8'h11, 8'h22, 2, 2'b01, 1'b1, 2'b01, 2, 8'h22, 25};
    vecs[3] = '{8'h00, 8'h5A, 8'h00, 1, 2'b11, 1'b0, 2'b00, 0, 8'h00, 25};
    vecs[4] = '{8'hA0, 8'hFF, 8'h00, 2, 2'b11, 1'b1, 2'b11, 2, 8'h00, 25};

    // reset state
    wq(10);
    chk("rst sda_drive_low", {31'd0, bus.sda_drive_low}, 32'd0);
    chk("rst rx_valid",      {31'd0, bus.rx_valid},      32'd0);
    chk("rst rx_data",       {24'd0, bus.rx_data},       32'd0);
    chk("rst tx_load",       {31'd0, bus.tx_load},       32'd0);
    chk("rst addressed",     {31'd0, bus.addressed},     32'd0);
    chk("rst bus_busy",      {31'd0, bus.bus_busy},      32'd0);
    reset_n = 1'b1;
    wq(10);

    // table-driven write transactions
    for (int v = 0; v < 5; v++) begin
      Q = vecs[v].q;
      rx0 = mon_rx;
      drv0 = mon_drv;
      m_ready = vecs[v].ready[0];
      i2c_start();
      chk($sformatf("v%0d busy_after_start", v), {31'd0, bus.bus_busy}, 32'd1);
      write_byte(vecs[v].addr, a);
      chk($sformatf("v%0d addr_ack", v), {31'd0, a}, {31'd0, vecs[v].exp_aack});
      for (int j = 0; j < 2; j++) begin
        if (j < int'(vecs[v].nbytes)) begin
          m_ready = vecs[v].ready[j];
          db = (j == 0) ? vecs[v].d0 : vecs[v].d1;
          write_byte(db, a);
          chk($sformatf("v%0d data%0d_ack", v, j), {31'd0, a}, {31'd0, vecs[v].exp_dack[j]});
        end
      end
      chk($sformatf("v%0d addressed", v), {31'd0, bus.addressed}, {31'd0, vecs[v].exp_aack});
      chk($sformatf("v%0d busy_mid", v), {31'd0, bus.bus_busy}, 32'd1);
      i2c_stop();
      wq(Q);
      chk($sformatf("v%0d busy_after_stop", v), {31'd0, bus.bus_busy}, 32'd0);
      chk($sformatf("v%0d addressed_after_stop", v), {31'd0, bus.addressed}, 32'd0);
      chk($sformatf("v%0d rx_count", v), mon_rx - rx0, vecs[v].exp_rx);
      if (vecs[v].exp_rx > 0)
        chk($sformatf("v%0d rx_data", v), {24'd0, mon_last}, {24'd0, vecs[v].exp_last});
      chk($sformatf("v%0d sda_driven", v), {31'd0, mon_drv != drv0}, {31'd0, vecs[v].exp_aack});
      m_ready = 1'b1;
      wq(4 * Q);
    end

    // read: 0xC5 ACKed, 0x0F NACKed
    Q = 25;
    rx0 = mon_rx;
    tx0 = mon_tx;
    m_txd = 8'hC5;
    i2c_start();
    write_byte(8'hA1, a);
    chk("rd addr_ack", {31'd0, a}, 32'd1);
    chk("rd addressed", {31'd0, bus.addressed}, 32'd1);
    read_bits(d);
    chk("rd byte0", {24'd0, d}, 32'hC5);
    m_txd = 8'h0F;
    bit_cycle(1'b0, a);
    read_bits(d);
    chk("rd byte1", {24'd0, d}, 32'h0F);
    bit_cycle(1'b1, a);
    chk("rd nack_seen", {31'd0, a}, 32'd1);
    chk("rd released", {31'd0, bus.sda_drive_low}, 32'd0);
    chk("rd tx_load_count", mon_tx - tx0, 32'd2);
    chk("rd no_rx", mon_rx - rx0, 32'd0);
    i2c_stop();
    wq(4 * Q);

    // repeated START after 4 bits of a data byte, then a read
    rx0 = mon_rx;
    tx0 = mon_tx;
    m_txd = 8'h96;
    i2c_start();
    write_byte(8'hA0, a);
    chk("rs addr_ack", {31'd0, a}, 32'd1);
    bit_cycle(1'b1, a);
    bit_cycle(1'b0, a);
    bit_cycle(1'b1, a);
    bit_cycle(1'b1, a);
    i2c_restart();
    chk("rs addressed_cleared", {31'd0, bus.addressed}, 32'd0);
    chk("rs busy_kept", {31'd0, bus.bus_busy}, 32'd1);
    write_byte(8'hA1, a);
    chk("rs readdr_ack", {31'd0, a}, 32'd1);
    read_bits(d);
    chk("rs rd_byte", {24'd0, d}, 32'h96);
    bit_cycle(1'b1, a);
    i2c_stop();
    wq(Q);
    chk("rs no_rx", mon_rx - rx0, 32'd0);
    chk("rs tx_load_count", mon_tx - tx0, 32'd1);
    wq(4 * Q);

    // reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      db = 8'hA0;
      bit_cycle(db[i], a);
    end
    chk("rr driving_ack", {31'd0, bus.sda_drive_low}, 32'd1);
    chk("rr addressed", {31'd0, bus.addressed}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rr sda_released", {31'd0, bus.sda_drive_low}, 32'd0);
    chk("rr addressed_0", {31'd0, bus.addressed}, 32'd0);
    chk("rr busy_0", {31'd0, bus.bus_busy}, 32'd0);
    chk("rr rx_data_0", {24'd0, bus.rx_data}, 32'd0);
    wq(3);
    @(negedge clk);
    reset_n = 1'b1;
    bit_cycle(1'b1, a);
    chk("rr no_ack_after_reset", {31'd0, a}, 32'd1);
    chk("rr still_idle", {31'd0, bus.sda_drive_low}, 32'd0);
    i2c_stop();
    wq(4 * Q);

    // recovery: normal write after the reset
    rx0 = mon_rx;
    m_ready = 1'b1;
    i2c_start();
    write_byte(8'hA0, a);
    chk("rc addr_ack", {31'd0, a}, 32'd1);
    write_byte(8'h81, a);
    chk("rc data_ack", {31'd0, a}, 32'd1);
    i2c_stop();
    wq(Q);
    chk("rc rx_count", mon_rx - rx0, 32'd1);
    chk("rc rx_data", {24'd0, mon_last}, 32'h81);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
